rca_pipe_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor that succeeds the fixed 8-bit combinational ripple adder. The WIDTH-bit operation is split into STAGES = WIDTH/CHUNK ripple segments, with one register stage per segment, so the critical path is one CHUNK-bit ripple. It accepts one operation per cycle through a valid/ready handshake and sits on the datapath between operand registers and the ALU result bus.

---
 rtl/rca_pipe_addsub.sv | 132 +++++++++++++
 tb/tb_rca_pipe_addsub.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe_addsub.sv
// rca_pipe_addsub
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit operation is cut into
// STAGES = WIDTH/CHUNK ripple segments with one register stage per segment, so
// the longest combinational path is a single CHUNK-bit ripple.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set present
//   in_ready   operand set accepted this cycle (advance && !rst)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (sub: 1 means no borrow)
//   ovf        two's-complement signed overflow

module rca_pipe_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;
   localparam int MSB    = WIDTH - 1;

   // Stage registers. a_q/b_q are the skew registers holding operand slices
   // not yet consumed; s_q accumulates the partial sum produced so far.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             ovf_q;

   // Inputs seen by each stage: primary inputs for stage 0, the previous
   // stage's registers otherwise.
   logic [WIDTH-1:0] si_a [STAGES];
   logic [WIDTH-1:0] si_b [STAGES];
   logic [WIDTH-1:0] si_s [STAGES];
   logic             si_c [STAGES];
   logic             si_v [STAGES];

   logic [CHUNK:0]   part  [STAGES];
   logic [WIDTH-1:0] s_nxt [STAGES];
   logic             ovf_nxt;
   logic             advance;

   // The whole pipe moves as one; a held output freezes every stage.
   assign advance  = out_ready || !out_valid;
   assign in_ready = advance && !rst;

   always_comb begin
      si_a[0] = a;
      si_b[0] = b ^ {WIDTH{sub}};
      si_s[0] = '0;
      si_c[0] = cin ^ sub;
      si_v[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         si_a[k] = a_q[k-1];
         si_b[k] = b_q[k-1];
         si_s[k] = s_q[k-1];
         si_c[k] = c_q[k-1];
         si_v[k] = v_q[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         part[k] = {1'b0, si_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, si_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, si_c[k]};
         s_nxt[k] = si_s[k];
         s_nxt[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      end
   end

   // Overflow needs the operand MSBs, which only the last stage sees together
   // with the final sum MSB, so it is resolved there and registered.
   assign ovf_nxt = (si_a[LAST][MSB] == si_b[LAST][MSB]) &&
                    (s_nxt[LAST][MSB] != si_a[LAST][MSB]);

   // Data registers only load behind a valid bit, so bubbles leave the last
   // result parked on the outputs instead of exposing bubble garbage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            c_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= si_v[k];
            if (si_v[k]) begin
               a_q[k] <= si_a[k];
               b_q[k] <= si_b[k];
               s_q[k] <= s_nxt[k];
               c_q[k] <= part[k][CHUNK];
            end
         end
         if (si_v[LAST]) begin
            ovf_q <= ovf_nxt;
         end
      end
   end

   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Testbench for rca_pipe_addsub: main instance at 32/8 plus three extra
// configurations (8/8, 16/4, 64/16) running concurrently.

module tb_rca_pipe_addsub;

   localparam int STG = 4;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, sum;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit sw_done [3];

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          ec;
   } exp_t;

   exp_t sbq [$];

   rca_pipe_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Returns {ovf, cout, sum[63:0]} for a w-bit add/sub.
   function automatic logic [65:0] model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                         input logic ci, input logic sb);
      logic [63:0] mask, am, bp, s;
      logic [64:0] full;
      logic        co, ov;
      mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      am   = ai & mask;
      bp   = (sb ? ~bi : bi) & mask;
      full = {1'b0, am} + {1'b0, bp} + {64'd0, ci ^ sb};
      s    = full[63:0] & mask;
      co   = full[w];
      ov   = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
      return {ov, co, s};
   endfunction

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb,
                       input logic [31:0] es, input logic ec, input logic eo,
                       input bit lat, input bit must);
      int   g;
      exp_t e;
      @(negedge clk);
      a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
      #1;
      if (must) chk("in_ready_thru", 66'(in_ready), 66'd1);
      g = 0;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (!in_ready) chk("accept_timeout", 66'(in_ready), 66'd1);
      e.s = es; e.c = ec; e.o = eo;
      e.ec = lat ? cyc + STG : -1;
      sbq.push_back(e);
   endtask

   task automatic sendm(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb,
                        input bit lat, input bit must);
      logic [65:0] m;
      m = model(32, {32'd0, av}, {32'd0, bv}, ci, sb);
      send(av, bv, ci, sb, m[31:0], m[64], m[65], lat, must);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int g;
      g = 0;
      while (sbq.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk(nm, 66'(sbq.size()), 66'd0);
   endtask

   // Scoreboard monitor for the main instance.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 66'(out_valid), 66'd0);
            end else begin
               e = sbq.pop_front();
               chk("result", {ovf, cout, 32'd0, sum}, {e.o, e.c, 32'd0, e.s});
               if (e.ec >= 0) chk("latency", 66'(cyc), 66'(e.ec));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] held;
      int          g;
      rst = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

      // Reset with in_valid held high
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("rst_out_valid", 66'(out_valid), 66'd0);
         chk("rst_sum", 66'(sum), 66'd0);
         chk("rst_cout_ovf", {64'd0, cout, ovf}, 66'd0);
         chk("rst_in_ready", 66'(in_ready), 66'd0);
      end
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_quiet", 66'(out_valid), 66'd0);
      end

      // Directed vectors, back to back, each checked for 4-cycle latency
      send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1, 1);
      send(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1, 1);
      send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1, 1);
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1, 1);
      send(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1, 1);
      send(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0, 1, 1);
      send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1, 1);
      send(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1, 1);
      idle();
      drain("drain_directed");

      // 16 back-to-back operations
      for (int i = 0; i < 16; i++)
         sendm($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1, 1);
      idle();
      drain("drain_thru");

      // Backpressure: stall 5 cycles with in_valid held high
      fork
         begin
            for (int i = 0; i < 8; i++)
               sendm($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0);
            idle();
         end
      join_none
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (out_valid !== 1'b1 && g < 50);
      out_ready = 1'b0;
      #1;
      held = sum;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #2;
         chk("stall_out_valid", 66'(out_valid), 66'd1);
         chk("stall_sum", 66'(sum), 66'(held));
         chk("stall_in_ready", 66'(in_ready), 66'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      drain("drain_bp");

      // Reset with three operations in flight
      sendm(32'h11111111, 32'h22222222, 1'b0, 1'b0, 0, 1);
      sendm(32'h33333333, 32'h44444444, 1'b0, 1'b0, 0, 1);
      sendm(32'h55555555, 32'h66666666, 1'b0, 1'b0, 0, 1);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      sbq.delete();
      #1;
      chk("midrst_in_ready", 66'(in_ready), 66'd0);
      @(negedge clk);
      #1;
      chk("midrst_out_valid", 66'(out_valid), 66'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("midrst_quiet", 66'(out_valid), 66'd0);
      end
      send(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1, 1);
      idle();
      drain("drain_midrst");

      // Wait for the other configurations
      g = 0;
      while (!(sw_done[0] && sw_done[1] && sw_done[2]) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      chk("sweep_done", {63'd0, sw_done[0], sw_done[1], sw_done[2]}, 66'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Parameter sweep instances
   for (genvar gi = 0; gi < 3; gi++) begin : sw
      localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : 64;
      localparam int C = (gi == 0) ? 8 : (gi == 1) ? 4 : 16;

      logic         rst_s, iv, ir, ci, sb, ov, orr, co, of;
      logic [W-1:0] as, bs, ss;
      logic [65:0]  q [$];

      rca_pipe_addsub #(.WIDTH(W), .CHUNK(C)) dut_s (
         .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir),
         .a(as), .b(bs), .cin(ci), .sub(sb),
         .out_valid(ov), .out_ready(orr),
         .sum(ss), .cout(co), .ovf(of)
      );

      initial begin
         logic [65:0] m;
         logic [63:0] ra, rb;
         logic        rc, rs;
         int          g;
         rst_s = 1'b1; iv = 1'b0; as = '0; bs = '0; ci = 1'b0; sb = 1'b0; orr = 1'b1;
         repeat (2) @(negedge clk);
         rst_s = 1'b0;
         fork
            begin
               repeat (60) begin
                  @(negedge clk);
                  orr = ($urandom_range(3) != 0);
               end
               @(negedge clk);
               orr = 1'b1;
            end
         join_none
         for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            if (i == 0) begin
               ra = {64{1'b1}}; rb = 64'd1; rc = 1'b0; rs = 1'b0;
            end
            @(negedge clk);
            as = ra[W-1:0]; bs = rb[W-1:0]; ci = rc; sb = rs; iv = 1'b1;
            #1;
            g = 0;
            while (!ir && g < 200) begin
               @(negedge clk);
               #1;
               g++;
            end
            if (!ir) chk("sw_accept_timeout", 66'(ir), 66'd1);
            m = model(W, ra, rb, rc, rs);
            q.push_back(m);
         end
         @(negedge clk);
         iv = 1'b0;
         g = 0;
         while (q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
         end
         chk("sw_drain", 66'(q.size()), 66'd0);
         sw_done[gi] = 1'b1;
      end

      initial begin
         logic [65:0] e;
         forever begin
            @(negedge clk);
            #3;
            if (ov === 1'b1 && orr === 1'b1) begin
               if (q.size() == 0) begin
                  chk("sw_unexpected", 66'(ov), 66'd0);
               end else begin
                  e = q.pop_front();
                  chk("sw_result", {of, co, 64'(ss)}, e);
               end
            end
         end
      end
   end

endmodule
